// File: rtl/ak4619_tdm_if.sv
// Pin-level and parallel-sample bundle between the AK4619 TDM engine and its neighbours.
// master = the TDM engine; slave = the codec/calibrator side.
interface ak4619_tdm_if #(
    parameter int SAMPLE_W = 16
);
    logic                bick;
    logic                lrck;
    logic                sdout1;
    logic                sdin1;
    logic                sample_clk;
    logic [SAMPLE_W-1:0] dac0;
    logic [SAMPLE_W-1:0] dac1;
    logic [SAMPLE_W-1:0] dac2;
    logic [SAMPLE_W-1:0] dac3;
    logic [SAMPLE_W-1:0] adc0;
    logic [SAMPLE_W-1:0] adc1;
    logic [SAMPLE_W-1:0] adc2;
    logic [SAMPLE_W-1:0] adc3;

    modport master (
        output bick, lrck, sdout1, sample_clk, adc0, adc1, adc2, adc3,
        input  sdin1, dac0, dac1, dac2, dac3
    );

    modport slave (
        input  bick, lrck, sdout1, sample_clk, adc0, adc1, adc2, adc3,
        output sdin1, dac0, dac1, dac2, dac3
    );
endinterface

// File: rtl/ak4619_tdm.sv
// TDM128 link to the AK4619: generates BICK/LRCK, shifts 4 DAC slots out on SDOUT1, captures 4 ADC slots from SDIN1.
// DAC words latched at a frame wrap go out in the next frame; ADC words appear on adcN at the wrap ending their frame.
module ak4619_tdm #(
    parameter int BCK_DIV  = 2,
    parameter int SAMPLE_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    ak4619_tdm_if.master bus
);
    localparam int            PW      = $clog2(BCK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(BCK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(BCK_DIV / 2);
    localparam logic [5:0]    SW_LAST = 6'(SAMPLE_W - 1);

    logic [PW-1:0]             phase;
    logic [PW-1:0]             phase_nxt;
    logic [6:0]                bit_cnt;
    logic [6:0]                bit_nxt;
    logic                      ph_wrap;
    logic                      frame_wrap;
    logic                      rx_edge;
    logic                      rx_take;
    logic                      rx_last;
    logic                      tx_bit;
    logic [SAMPLE_W-1:0]       tx_word;
    logic [SAMPLE_W-1:0]       tx_shift;
    logic [SAMPLE_W-1:0]       rx_word;
    logic [SAMPLE_W-1:0]       rxsh;
    logic [3:0][SAMPLE_W-1:0]  dac_arr;
    logic [3:0][SAMPLE_W-1:0]  txhold;
    logic [3:0][SAMPLE_W-1:0]  rxhold;
    logic [3:0][SAMPLE_W-1:0]  adc_q;
    logic                      bick_q;
    logic                      lrck_q;
    logic                      sdout_q;

    assign dac_arr = {bus.dac3, bus.dac2, bus.dac1, bus.dac0};

    always_comb begin
        ph_wrap    = (phase == PH_LAST);
        phase_nxt  = ph_wrap ? '0 : phase + 1'b1;
        bit_nxt    = ph_wrap ? bit_cnt + 7'd1 : bit_cnt;
        frame_wrap = ph_wrap && (bit_cnt == 7'd127);
        rx_edge    = (phase_nxt == PH_HALF);
        rx_take    = ({1'b0, bit_cnt[4:0]} <= SW_LAST);
        rx_last    = ({1'b0, bit_cnt[4:0]} == SW_LAST);
        rx_word    = {rxsh[SAMPLE_W-2:0], bus.sdin1};
        // Bit 0 of a new frame must already come from the DAC word latched on this same edge.
        tx_word    = frame_wrap ? dac_arr[0] : txhold[bit_nxt[6:5]];
        // Shifting past the word leaves zeros in the MSB, which pads the slot tail.
        tx_shift   = tx_word << bit_nxt[4:0];
        tx_bit     = tx_shift[SAMPLE_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= '0;
            bit_cnt <= '0;
            bick_q  <= 1'b0;
            lrck_q  <= 1'b0;
            sdout_q <= 1'b0;
            rxsh    <= '0;
            rxhold  <= '0;
            txhold  <= '0;
            adc_q   <= '0;
        end else begin
            phase   <= phase_nxt;
            bit_cnt <= bit_nxt;
            bick_q  <= (phase_nxt >= PH_HALF);
            lrck_q  <= ~bit_nxt[6];
            if (ph_wrap) begin
                sdout_q <= tx_bit;
            end
            if (rx_edge && rx_take) begin
                rxsh <= rx_word;
                if (rx_last) begin
                    rxhold[bit_cnt[6:5]] <= rx_word;
                end
            end
            if (frame_wrap) begin
                adc_q  <= rxhold;
                txhold <= dac_arr;
            end
        end
    end

    assign bus.bick       = bick_q;
    assign bus.lrck       = lrck_q;
    assign bus.sample_clk = lrck_q;
    assign bus.sdout1     = sdout_q;
    assign bus.adc0       = adc_q[0];
    assign bus.adc1       = adc_q[1];
    assign bus.adc2       = adc_q[2];
    assign bus.adc3       = adc_q[3];
endmodule

// File: tb/tb_ak4619_tdm.sv
// Bench for ak4619_tdm: one instance at BCK_DIV=2 and one at BCK_DIV=4, driven by a table of
// DAC/codec words plus hand sequences for reset, framing periods, loopback and mid-frame reset.
module tb_ak4619_tdm;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ak4619_tdm_if #(.SAMPLE_W(16)) bus_a ();
    ak4619_tdm_if #(.SAMPLE_W(16)) bus_b ();

    ak4619_tdm #(.BCK_DIV(2), .SAMPLE_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    ak4619_tdm #(.BCK_DIV(4), .SAMPLE_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [3:0][15:0] dacv  [2];
    logic [3:0][15:0] rxw   [2];
    logic [3:0][15:0] adc_o [2];
    logic [1:0]       bick_o, lrck_o, sdout_o, sclk_o, sdin_codec, loop_en;

    assign bus_a.dac0  = dacv[0][0];
    assign bus_a.dac1  = dacv[0][1];
    assign bus_a.dac2  = dacv[0][2];
    assign bus_a.dac3  = dacv[0][3];
    assign bus_b.dac0  = dacv[1][0];
    assign bus_b.dac1  = dacv[1][1];
    assign bus_b.dac2  = dacv[1][2];
    assign bus_b.dac3  = dacv[1][3];
    assign bus_a.sdin1 = loop_en[0] ? bus_a.sdout1 : sdin_codec[0];
    assign bus_b.sdin1 = loop_en[1] ? bus_b.sdout1 : sdin_codec[1];
    assign bick_o      = {bus_b.bick, bus_a.bick};
    assign lrck_o      = {bus_b.lrck, bus_a.lrck};
    assign sdout_o     = {bus_b.sdout1, bus_a.sdout1};
    assign sclk_o      = {bus_b.sample_clk, bus_a.sample_clk};
    assign adc_o[0]    = {bus_a.adc3, bus_a.adc2, bus_a.adc1, bus_a.adc0};
    assign adc_o[1]    = {bus_b.adc3, bus_b.adc2, bus_b.adc1, bus_b.adc0};

    int n_vec = 0;
    int n_bad = 0;

    // Codec-side bit tracking, rebuilt from the pins only.
    int           cnt     [2];
    int           wraps   [2];
    logic         started [2];
    logic         bick_p  [2];
    logic         lrck_p  [2];
    logic [127:0] tx_cur  [2];
    logic [127:0] tx_last [2];

    typedef struct {
        int               d;
        logic [3:0][15:0] dac;
        logic [3:0][15:0] rx;
        logic [3:0][15:0] exp_tx;
        logic [3:0][15:0] exp_adc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][15:0] w4(input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] a2, input logic [15:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic codec_bit(input int d, input int c);
        logic [15:0] w;
        int          g;
        if (c > 127) return 1'b0;
        w = rxw[d][2'(c / 32)];
        if ((c % 32) < 16) return w[4'(15 - (c % 32))];
        g = int'($urandom_range(1, 0));
        return g[0];
    endfunction

    function automatic logic [15:0] tx_word_at(input int d, input int s, input int off);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[4'(15 - i)] = tx_last[d][7'(s * 32 + off + i)];
        return w;
    endfunction

    // Codec model: follows BICK/LRCK, records SDOUT1 at BICK rise, drives SDIN1 with a glitch
    // that settles well before the next sampling edge.
    always @(posedge clk) begin
        logic good [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                cnt[d]     = 0;
                started[d] = 1'b0;
            end else begin
                if (lrck_o[d] && !lrck_p[d]) begin
                    if (started[d]) begin
                        wraps[d]++;
                        tx_last[d] = tx_cur[d];
                    end
                    started[d] = 1'b1;
                    cnt[d]     = 0;
                end else if (!bick_o[d] && bick_p[d]) begin
                    cnt[d]++;
                end
                if (bick_o[d] && !bick_p[d] && cnt[d] < 128) tx_cur[d][7'(cnt[d])] = sdout_o[d];
            end
            bick_p[d]     = bick_o[d];
            lrck_p[d]     = lrck_o[d];
            good[d]       = codec_bit(d, cnt[d]);
            sdin_codec[d] = ~good[d];
        end
        #2;
        for (int d = 0; d < 2; d++) sdin_codec[d] = good[d];
    end

    task automatic wait_wraps(input int d, input int n);
        int target;
        int budget;
        target = wraps[d] + n;
        budget = (n + 1) * 600;
        while (wraps[d] < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (wraps[d] < target) begin
            n_vec++;
            n_bad++;
            $display("FAIL wrap_timeout dut%0d: got %0d wraps, want %0d", d, wraps[d], target);
        end
    endtask

    function automatic logic sig(input int sel, input int d);
        return (sel != 0) ? lrck_o[d] : bick_o[d];
    endfunction

    // High/low durations in clk cycles of BICK (sel=0) or LRCK (sel=1), starting at a rise.
    task automatic edge_times(input int sel, input int d, output int hi, output int lo);
        logic p;
        int   b;
        b  = 3000;
        hi = 0;
        lo = 0;
        p  = sig(sel, d);
        while (b > 0 && !(sig(sel, d) && !p)) begin
            p = sig(sel, d);
            @(negedge clk);
            b--;
        end
        hi = 1;
        while (b > 0) begin
            @(negedge clk);
            b--;
            if (sig(sel, d)) hi++; else break;
        end
        lo = 1;
        while (b > 0) begin
            @(negedge clk);
            b--;
            if (!sig(sel, d)) lo++; else break;
        end
    endtask

    task automatic run_loop(input int d);
        int t;
        int b;
        int bad;
        loop_en[d] = 1'b1;
        dacv[d]    = '0;
        wait_wraps(d, 2);
        chk($sformatf("lb_flush%0d", d), adc_o[d], 64'h0);
        repeat (5) @(negedge clk);
        dacv[d][2] = 16'hBEEF;
        wait_wraps(d, 1);
        chk($sformatf("lb_wrap1_%0d", d), adc_o[d][2], 16'h0000);
        wait_wraps(d, 1);
        chk($sformatf("lb_wrap2_%0d", d), adc_o[d][2], 16'hBEEF);
        repeat (20) @(negedge clk);
        dacv[d][2] = 16'h1111;
        t   = wraps[d] + 1;
        b   = 1200;
        bad = 0;
        while (wraps[d] < t && b > 0) begin
            @(negedge clk);
            b--;
            if (wraps[d] < t && adc_o[d][2] !== 16'hBEEF) bad++;
        end
        chk($sformatf("lb_hold%0d", d), 64'(bad), 64'h0);
        chk($sformatf("lb_after%0d", d), adc_o[d][2], 16'hBEEF);
        wait_wraps(d, 1);
        chk($sformatf("lb_next%0d", d), adc_o[d][2], 16'h1111);
        loop_en[d] = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        vec_t vecs [4];
        int   hi;
        int   lo;
        int   b;
        int   t;
        int   bad;

        vecs[0] = '{0, w4(16'h1234, 16'hABCD, 16'h8000, 16'h7FFF), w4(16'hCAFE, 16'h0001, 16'hFFFF, 16'h8000),
                       w4(16'h1234, 16'hABCD, 16'h8000, 16'h7FFF), w4(16'hCAFE, 16'h0001, 16'hFFFF, 16'h8000)};
        vecs[1] = '{0, w4(16'h0000, 16'hFFFF, 16'h5A5A, 16'h0001), w4(16'h7FFF, 16'h8000, 16'h0000, 16'hA5A5),
                       w4(16'h0000, 16'hFFFF, 16'h5A5A, 16'h0001), w4(16'h7FFF, 16'h8000, 16'h0000, 16'hA5A5)};
        vecs[2] = '{1, w4(16'h1234, 16'hABCD, 16'h8000, 16'h7FFF), w4(16'hCAFE, 16'h0001, 16'hFFFF, 16'h8000),
                       w4(16'h1234, 16'hABCD, 16'h8000, 16'h7FFF), w4(16'hCAFE, 16'h0001, 16'hFFFF, 16'h8000)};
        vecs[3] = '{1, w4(16'h8000, 16'h7FFF, 16'h0F0F, 16'hF0F0), w4(16'h1234, 16'hABCD, 16'h8000, 16'h7FFF),
                       w4(16'h8000, 16'h7FFF, 16'h0F0F, 16'hF0F0), w4(16'h1234, 16'hABCD, 16'h8000, 16'h7FFF)};

        rst_n   = 1'b0;
        dacv[0] = '0;
        dacv[1] = '0;
        rxw[0]  = '0;
        rxw[1]  = '0;
        loop_en = '0;
        for (int d = 0; d < 2; d++) begin
            wraps[d]   = 0;
            tx_cur[d]  = '0;
            tx_last[d] = '0;
        end

        // Reset state and first LRCK rise
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_pins%0d", d), {bick_o[d], lrck_o[d], sdout_o[d], sclk_o[d]}, 4'b0000);
            chk($sformatf("rst_adc%0d", d), adc_o[d], 64'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("lrck_first", {lrck_o, sclk_o}, 4'b1111);

        // Clock periods
        for (int d = 0; d < 2; d++) begin
            edge_times(0, d, hi, lo);
            chk($sformatf("bick_hi%0d", d), 64'(hi), 64'(d == 0 ? 1 : 2));
            chk($sformatf("bick_lo%0d", d), 64'(lo), 64'(d == 0 ? 1 : 2));
            edge_times(1, d, hi, lo);
            chk($sformatf("lrck_hi%0d", d), 64'(hi), 64'(d == 0 ? 128 : 256));
            chk($sformatf("lrck_lo%0d", d), 64'(lo), 64'(d == 0 ? 128 : 256));
        end

        // Table: DAC words out on SDOUT1, codec words into adcN
        foreach (vecs[i]) begin
            dacv[vecs[i].d] = vecs[i].dac;
            rxw[vecs[i].d]  = vecs[i].rx;
            wait_wraps(vecs[i].d, 2);
            for (int s = 0; s < 4; s++) begin
                chk($sformatf("v%0d_tx%0d", i, s), tx_word_at(vecs[i].d, s, 0), vecs[i].exp_tx[s]);
                chk($sformatf("v%0d_pad%0d", i, s), tx_word_at(vecs[i].d, s, 16), 16'h0000);
                chk($sformatf("v%0d_adc%0d", i, s), adc_o[vecs[i].d][s], vecs[i].exp_adc[s]);
            end
        end

        // Loopback latency and mid-frame DAC change
        run_loop(0);
        run_loop(1);

        // Reset at bit 70, then one full frame before any adc update
        rxw[0] = w4(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0);
        wait_wraps(0, 2);
        chk("pre_rst_adc", adc_o[0], w4(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0));
        b = 600;
        while (cnt[0] != 70 && b > 0) begin
            @(negedge clk);
            b--;
        end
        chk("bit70_reached", 64'(cnt[0]), 64'd70);
        rst_n = 1'b0;
        #1;
        chk("midrst_pins", {bick_o[0], lrck_o[0], sdout_o[0], sclk_o[0]}, 4'b0000);
        chk("midrst_adc", adc_o[0], 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t   = wraps[0] + 1;
        b   = 1200;
        bad = 0;
        while (wraps[0] < t && b > 0) begin
            @(negedge clk);
            b--;
            if (wraps[0] < t && adc_o[0] !== 64'h0) bad++;
        end
        chk("postrst_no_early", 64'(bad), 64'h0);
        chk("postrst_adc", adc_o[0], w4(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
